input_debouncer: RTL and testbench
==================================

# input_debouncer

Per-bit debouncer and edge-event collector for asynchronous external inputs (buttons, limit switches, strap pins). It sits directly downstream of the multi-stage `synchronizer`, and its `in` bus is the synchronizer's `out` in the same clock domain. Each bit is accepted only after it has held a new level for a programmable number of consecutive cycles. The block then reports the clean level, single-cycle edge pulses, and an accumulated event word over a valid/ready handshake for the control FSM.

## Interface
- `Width`, 8: number of independent input bits.
- `Cycles`, 1000: consecutive differing cycles needed to accept a new level. Must be ≥ 1. Counter width is `$clog2(Cycles+1)`.
- `InitValue`, 0: reset value of `state`, taken as `InitValue[Width-1:0]`.
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion must be synchronous to `clk`.
- `in`  in  Width: already-synchronized raw inputs.
- `state`  out  Width: debounced level.
- `rise`  out  Width: one-cycle pulse, set when `state[i]` goes 0→1.
- `fall`  out  Width: one-cycle pulse, set when `state[i]` goes 1→0.
- `event_valid`  out  1: at least one pending edge is held.
- `event_ready`  in  1: consumer accepts the pending event word.
- `event_rise`  out  Width: accumulated pending rising edges.
- `event_fall`  out  Width: accumulated pending falling edges.

## Operation
- Reset values:
  - `state` = `InitValue`.
  - All counters = 0.
  - `rise`, `fall`, `event_rise`, `event_fall` = 0.
  - `event_valid` = 0.
- Per bit i, evaluated at each edge:
  - If `in[i] == state[i]`: `cnt[i]` is set to 0.
  - Else, if `cnt[i] == Cycles-1`: `state[i]` takes `in[i]`, `cnt[i]` is set to 0, and `rise[i]` or `fall[i]` is registered to 1 according to direction.
  - Else: `cnt[i]` increments.
- `rise`/`fall` are registered and last exactly one cycle. They are never both set on the same bit in the same cycle.
- Any return to the old level before the Cycles-th cycle clears the counter. No edge is reported.
- Bits are fully independent. Several bits may change in the same cycle.
- Event accumulator:
  - `event_valid = |event_rise | |event_fall`.
  - On an edge with `event_valid && event_ready`, pending is loaded with this edge's new rise/fall bits. Simultaneous edges are never lost.
  - Otherwise pending is ORed with the new rise/fall bits.
  - A bit may show both rise and fall pending if it toggled twice before being consumed.
- `event_ready` has no effect while `event_valid` = 0.
- Reset mid-debounce discards counters and pending events. `state` returns to `InitValue`.

## Timing
- `in` changes before edge E1 and holds → `state` and the edge pulse change at edge E`Cycles`. Latency from a stable `in` to `state` is `Cycles` clocks.
- With `Cycles` = 1, `state` follows `in` one cycle late and every change yields a pulse.
- `event_*` update on the same edge as `state`. `event_valid` rises on that edge.
- `event_*` outputs are stable while `event_valid && !event_ready`, except that new edges are ORed in.
- Combined latency: the upstream synchronizer adds `Stages` cycles before this block.

## Configuration
- `INPUT_DEBOUNCER_EVENT_EN` defined: the event accumulator and handshake are built as described.
- Not defined: no pending registers are built. `event_valid`, `event_rise` and `event_fall` are tied to 0, and `event_ready` is ignored. `state`, `rise` and `fall` behave identically in both builds.

## Test plan
- Reset, `InitValue`=8'hA5, `reset_n` low then high → `state`=8'hA5; `rise`, `fall` and `event_valid` = 0.
- `Cycles`=4; `in[0]` 0→1 held 4 cycles → `state[0]`=1 at the 4th edge; `rise`=8'h01 for exactly one cycle; `event_rise`=8'h01 and `event_valid`=1 until accepted.
- `Cycles`=4; `in[3]` glitch high for 3 cycles, then back to 0 → `state`, `rise` and `event_valid` unchanged.
- `Cycles`=4; bits 1 and 2 change together, `event_ready` held 0 → `event_rise`=8'h06 after 4 edges; a later fall on bit 1 gives `event_fall`=8'h02 with `event_rise` still 8'h06.
- Handshake accepted on the same edge that bit 5 rises → pending becomes `event_rise`=8'h20 and `event_valid` stays 1.
- `reset_n` pulsed low 2 cycles into a 4-cycle debounce → no pulse; `state` returns to `InitValue`; the debounce restarts its full count after reset.

Source files
------------

// File: rtl/input_debouncer.sv
// Per-bit debouncer with registered edge pulses and an optional pending-edge accumulator.
// Define INPUT_DEBOUNCER_EVENT_EN to build the event word and its valid/ready handshake.
module input_debouncer #(
  parameter int               Width     = 8,
  parameter int               Cycles    = 1000,
  parameter logic [Width-1:0] InitValue = '0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] state_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             event_valid_o,
  input  logic             event_ready_i,
  output logic [Width-1:0] event_rise_o,
  output logic [Width-1:0] event_fall_o
);

  localparam int              CntW    = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  logic [Width-1:0] state_q, state_d;
  logic [Width-1:0] rise_q, rise_d;
  logic [Width-1:0] fall_q, fall_d;

  // A bit flips only after Cycles consecutive cycles of disagreement with state.
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (in_i[i] != state_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          state_d[i] = in_i[i];
          rise_d[i]  = in_i[i];
          fall_d[i]  = ~in_i[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= InitValue;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < Width; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < Width; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef INPUT_DEBOUNCER_EVENT_EN
  logic [Width-1:0] ev_rise_q, ev_rise_d;
  logic [Width-1:0] ev_fall_q, ev_fall_d;
  logic             ev_valid;

  assign ev_valid = (|ev_rise_q) | (|ev_fall_q);

  // On acceptance the word is replaced, not cleared, so same-edge events survive.
  always_comb begin
    if (ev_valid && event_ready_i) begin
      ev_rise_d = rise_d;
      ev_fall_d = fall_d;
    end else begin
      ev_rise_d = ev_rise_q | rise_d;
      ev_fall_d = ev_fall_q | fall_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ev_rise_q <= '0;
      ev_fall_q <= '0;
    end else begin
      ev_rise_q <= ev_rise_d;
      ev_fall_q <= ev_fall_d;
    end
  end

  assign event_valid_o = ev_valid;
  assign event_rise_o  = ev_rise_q;
  assign event_fall_o  = ev_fall_q;
`else
  logic unused_event_ready;
  assign unused_event_ready = event_ready_i;
  assign event_valid_o      = 1'b0;
  assign event_rise_o       = '0;
  assign event_fall_o       = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed vector bench for input_debouncer with Cycles=4, InitValue=8'hA5.
// Event expectations collapse to zero when the accumulator is not built.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EVENT_EN
  localparam bit EvEn = 1'b1;
`else
  localparam bit EvEn = 1'b0;
`endif
  localparam logic [7:0] Init = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_v;
  logic       ready;
  logic [7:0] state, rise, fall, ev_rise, ev_fall;
  logic       ev_valid;

  int checks = 0;
  int errors = 0;

  input_debouncer #(.Width(8), .Cycles(4), .InitValue(Init)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .in_i          (in_v),
    .state_o       (state),
    .rise_o        (rise),
    .fall_o        (fall),
    .event_valid_o (ev_valid),
    .event_ready_i (ready),
    .event_rise_o  (ev_rise),
    .event_fall_o  (ev_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic       rdy;
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic [7:0] er;
    logic [7:0] ef;
    logic       ev;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] i, input logic r, input logic [7:0] s,
                     input logic [7:0] ri, input logic [7:0] fa,
                     input logic [7:0] er, input logic [7:0] ef, input logic ev);
    vec_t v;
    v.in = i; v.rdy = r; v.st = s; v.ri = ri; v.fa = fa;
    v.er = er; v.ef = ef; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [7:0] s, input logic [7:0] ri,
                         input logic [7:0] fa, input logic [7:0] er,
                         input logic [7:0] ef, input logic ev);
    chk("state", idx, state, s);
    chk("rise", idx, rise, ri);
    chk("fall", idx, fall, fa);
    chk("event_rise", idx, ev_rise, er & {8{EvEn}});
    chk("event_fall", idx, ev_fall, ef & {8{EvEn}});
    chk("event_valid", idx, {7'd0, ev_valid}, {7'd0, ev & EvEn});
  endtask

  initial begin
    //   in     rdy  state  rise   fall   ev_r   ev_f   valid
    // bit 0 falls, then is accepted
    add(8'hA4, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA4, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA4, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA4, 0, 8'hA4, 8'h00, 8'h01, 8'h00, 8'h01, 1);
    add(8'hA4, 1, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // bit 0 rises; event held until accepted
    add(8'hA5, 0, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 1);
    add(8'hA5, 0, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 1);
    add(8'hA5, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // bit 3 glitches high for 3 cycles, twice
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAD, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hA5, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // bits 1 and 3 rise together, then bit 1 falls, ready held low
    add(8'hAF, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAF, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAF, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hAF, 0, 8'hAF, 8'h0A, 8'h00, 8'h0A, 8'h00, 1);
    add(8'hAD, 0, 8'hAF, 8'h00, 8'h00, 8'h0A, 8'h00, 1);
    add(8'hAD, 0, 8'hAF, 8'h00, 8'h00, 8'h0A, 8'h00, 1);
    add(8'hAD, 0, 8'hAF, 8'h00, 8'h00, 8'h0A, 8'h00, 1);
    add(8'hAD, 0, 8'hAD, 8'h00, 8'h02, 8'h0A, 8'h02, 1);
    add(8'hAD, 0, 8'hAD, 8'h00, 8'h00, 8'h0A, 8'h02, 1);
    // bit 4 rises on the same edge the pending word is accepted
    add(8'hBD, 0, 8'hAD, 8'h00, 8'h00, 8'h0A, 8'h02, 1);
    add(8'hBD, 0, 8'hAD, 8'h00, 8'h00, 8'h0A, 8'h02, 1);
    add(8'hBD, 0, 8'hAD, 8'h00, 8'h00, 8'h0A, 8'h02, 1);
    add(8'hBD, 1, 8'hBD, 8'h10, 8'h00, 8'h10, 8'h00, 1);
    add(8'hBD, 0, 8'hBD, 8'h00, 8'h00, 8'h10, 8'h00, 1);
    add(8'hBD, 1, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hBD, 1, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // bit 6 rises while bit 0 falls, then bit 6 falls before consumption
    add(8'hFC, 0, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hFC, 0, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hFC, 0, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'hFC, 0, 8'hFC, 8'h40, 8'h01, 8'h40, 8'h01, 1);
    add(8'hBC, 0, 8'hFC, 8'h00, 8'h00, 8'h40, 8'h01, 1);
    add(8'hBC, 0, 8'hFC, 8'h00, 8'h00, 8'h40, 8'h01, 1);
    add(8'hBC, 0, 8'hFC, 8'h00, 8'h00, 8'h40, 8'h01, 1);
    add(8'hBC, 0, 8'hBC, 8'h00, 8'h40, 8'h40, 8'h41, 1);
    add(8'hBC, 1, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // reset state
    reset_n = 1'b0;
    in_v    = Init;
    ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all(-1, Init, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    foreach (vecs[k]) begin
      @(negedge clk);
      in_v  = vecs[k].in;
      ready = vecs[k].rdy;
      @(posedge clk);
      #1;
      chk_all(k, vecs[k].st, vecs[k].ri, vecs[k].fa, vecs[k].er, vecs[k].ef, vecs[k].ev);
    end

    // reset two cycles into a debounce of bit 1
    @(negedge clk);
    in_v  = 8'hBE;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(100, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all(101, Init, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all(102, Init, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    // in=BE vs A5: bits 1,3,4 rise and bit 0 falls after a full count
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk_all(102 + e, Init, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    @(posedge clk);
    #1;
    chk_all(106, 8'hBE, 8'h1A, 8'h01, 8'h1A, 8'h01, 1'b1);
    @(posedge clk);
    #1;
    chk_all(107, 8'hBE, 8'h00, 8'h00, 8'h1A, 8'h01, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
